// File: rtl/rr_mux_arbiter_if.sv
// Shared-channel bundle between four sources, the round-robin arbiter and its consumer.
// The master side is the arbiter; the slave side is the sources plus the consumer.
interface rr_mux_arbiter_if #(
  parameter int DW = 8
);
  logic [3:0]    req;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [DW-1:0] c;
  logic [DW-1:0] d;
  logic          out_ready;
  logic          out_valid;
  logic [DW-1:0] y;
  logic [3:0]    gnt;
  logic          s1;
  logic          s0;
  logic          busy;
  logic          state_dbg;

  // Handshake: a beat transfers on a rising clk edge when out_valid && out_ready;
  // out_valid never waits on out_ready, and y is stable while out_valid is high
  // unless the granted source itself changes its data.
  modport master (
    input  req, a, b, c, d, out_ready,
    output out_valid, y, gnt, s1, s0, busy, state_dbg
  );

  modport slave (
    output req, a, b, c, d, out_ready,
    input  out_valid, y, gnt, s1, s0, busy, state_dbg
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux channel among four requesters,
// with each grant capped at MAX_HOLD transfers.
module rr_mux_arbiter #(
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  rr_mux_arbiter_if.master bus
);
  localparam int CW = $clog2(MAX_HOLD) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_HOLD - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          out_valid;
  logic [DW-1:0] y;
  logic          xfer;
  logic          release_grant;
  logic          found;
  logic [1:0]    win;
  logic [1:0]    idx;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd3;
      sel_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Rotating-priority search starting just after the last winner.
  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    idx   = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign xfer          = out_valid && bus.out_ready;
  assign release_grant = !bus.req[sel_q] || (xfer && (cnt_q == LAST_BEAT));

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          sel_d   = win;
          gnt_d   = 4'b0001 << win;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (release_grant) begin
          state_d = IDLE;
          ptr_d   = sel_q;
          gnt_d   = 4'b0000;
          cnt_d   = '0;
        end else if (xfer) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    out_valid = (state_q == GRANT) && bus.req[sel_q];
    y         = '0;
    if (out_valid) begin
      case (sel_q)
        2'd0:    y = bus.a;
        2'd1:    y = bus.b;
        2'd2:    y = bus.c;
        default: y = bus.d;
      endcase
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.y         = y;
  assign bus.gnt       = gnt_q;
  assign bus.s1        = sel_q[1];
  assign bus.s0        = sel_q[0];
  assign bus.busy      = (state_q == GRANT);
  assign bus.state_dbg = state_q;
endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter/controller that shares one 4-to-1 mux output channel between four requesters (a, b, c, d).
- Generates the mux selects s1/s0 and a one-hot grant, and presents the selected data on a valid/ready output port.
- Bounds each grant to MAX_HOLD transfers so no requester can starve the others.
- Sits between the four source blocks and the single downstream consumer of the shared channel.

Parameters:
- DW, 8, data width of each input and of y.
- MAX_HOLD, 4, max transfers per grant (>=1); cnt width = clog2(MAX_HOLD)+1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request per source; bit0=a, bit1=b, bit2=c, bit3=d.
- a  input  DW  data of source 0.
- b  input  DW  data of source 1.
- c  input  DW  data of source 2.
- d  input  DW  data of source 3.
- out_ready  input  1  downstream can accept y this cycle.
- out_valid  output  1  y holds a valid beat.
- y  output  DW  selected data.
- gnt  output  4  registered one-hot grant.
- s1  output  1  mux select MSB (registered).
- s0  output  1  mux select LSB (registered).
- busy  output  1  high while in GRANT.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE, gnt=0000, {s1,s0}=00, busy=0.
  - Internal last-winner pointer ptr=3, so source a wins the first arbitration; beat counter cnt=0.
  - out_valid=0 and y=0, because both are derived from state.
- Reset asserted mid-grant clears all state immediately. A beat presented in that cycle is not counted as transferred.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the first set req bit scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - Register sel=winner index ({s1,s0}: a=00, b=01, c=10, d=11), gnt=1<<winner, cnt=0, and go to GRANT.
  - Latency: req rising in cycle N gives gnt/busy high in cycle N+1.
- GRANT:
  - out_valid = req[sel] (combinational).
  - y = out_valid ? input selected by {s1,s0} : 0.
  - Transfer = out_valid && out_ready. On a transfer, cnt increments.
- Release from GRANT (checked at the clock edge) occurs when either:
  - req[sel]==0, or
  - a transfer occurs with cnt==MAX_HOLD-1.
- On release: ptr=sel, gnt=0000, cnt=0, state=IDLE. {s1,s0} keep their last value.
- Between consecutive grants there is exactly one IDLE cycle, even when other requests are pending.
- Back-pressure: while out_ready=0 and req[sel]=1, the grant is held indefinitely. cnt and sel do not change, and y follows the live selected input.
- Requester changes:
  - A requester dropping req during its grant deasserts out_valid in the same cycle; release happens at the next edge.
  - req changes on non-granted sources have no effect during GRANT.
- Simultaneous requests resolve purely by rotating priority; there are no fixed priorities.
- busy = (state==GRANT). gnt is nonzero only in GRANT and always one-hot.

Test Plan:
- Reset, then req=0001, a=8'hA5, out_ready=1, held -> gnt=0001 one cycle after req; {s1,s0}=00; y=A5 for exactly 4 beats (MAX_HOLD=4); then gnt=0000 for one cycle; then a is re-granted.
- req=1111 held, out_ready=1, a/b/c/d=11/22/33/44 -> grant order a,b,c,d,a with 4 beats each; {s1,s0} sequence 00,01,10,11; one IDLE bubble between grants.
- Grant on c (req=0100), out_ready=0 for 10 cycles then 1 -> out_valid=1 and gnt=0100 held throughout; cnt frozen; 4 beats of c counted only after out_ready rises.
- Grant on b, b drops req after 2 beats while req=1001 -> out_valid falls the same cycle; next winner is d (ptr=1 gives scan order c,d,a); {s1,s0}=11.
- rst_n pulsed low mid-grant on d -> gnt, busy, out_valid, y and {s1,s0} go to 0 immediately without a clock; the first grant after reset goes to a if req[0]=1.
- MAX_HOLD=1 build, req=0011 -> grants alternate a,b with one beat each; no source granted twice in a row while the other requests.
